// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: Philips-format I2S receiver. Oversamples SCK/WS/SD on the
// system clock, frames one dummy bit plus DATA_WIDTH MSB-first data bits per
// slot, and presents each word on a valid/ready stream tagged with its channel.
//
// Handshake: a word is transferred on every clk where pcm_valid_o && pcm_ready_i.
// While valid is high and ready is low, pcm_data_o/pcm_right_o hold steady.
// A word that completes while the output is still full is dropped (overrun_o).
module i2s_rx_capture #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    output logic [DATA_WIDTH-1:0] pcm_data_o,
    output logic                  pcm_right_o,
    output logic                  pcm_valid_o,
    input  logic                  pcm_ready_i,
    output logic                  frame_err_o,
    output logic [7:0]            err_count_o,
    output logic                  overrun_o,
    output logic [1:0]            dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_SEEK = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sck_d;

    state_t                 r_state;
    logic                   r_ws_prev;
    logic                   r_chan;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-2:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_pcm_data;
    logic                   r_pcm_right;
    logic                   r_pcm_valid;
    logic                   r_frame_err;
    logic [7:0]             r_err_count;
    logic                   r_overrun;

    logic                   w_sck_s;
    logic                   w_ws_s;
    logic                   w_sd_s;
    logic                   w_sck_rise;
    logic                   w_ws_edge;
    logic [DATA_WIDTH-1:0]  w_word;
    logic                   w_out_free;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_ws_s     = r_ws_sync[SYNC_STAGES-1];
    assign w_sd_s     = r_sd_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_ws_edge  = w_ws_s ^ r_ws_prev;
    // The completed word is the held bits plus the bit arriving this sck_rise.
    assign w_word     = {r_shift, w_sd_s};
    assign w_out_free = ~r_pcm_valid | pcm_ready_i;

    // Bring the asynchronous I2S pins into the clk_i domain, all with equal delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_d    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
            r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws_i};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], sd_i};
            r_sck_d    <= w_sck_s;
        end
    end

    // Slot framing FSM with the output register and error reporting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_SEEK;
            r_ws_prev   <= 1'b0;
            r_chan      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_pcm_data  <= '0;
            r_pcm_right <= 1'b0;
            r_pcm_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_pcm_valid && pcm_ready_i) begin
                r_pcm_valid <= 1'b0;
            end
            if (w_sck_rise) begin
                r_ws_prev <= w_ws_s;
                case (r_state)
                    ST_SEEK: begin
                        // Wait for a slot boundary; the edge bit is the dummy bit.
                        if (w_ws_edge) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_chan    <= w_ws_s;
                        end
                    end
                    ST_DATA: begin
                        if (w_ws_edge) begin
                            // Slot ended early: drop the partial word, restart.
                            r_frame_err <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_bit_cnt <= '0;
                            r_chan    <= w_ws_s;
                        end else begin
                            r_shift   <= w_word[DATA_WIDTH-2:0];
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= ST_PAD;
                                if (w_out_free) begin
                                    r_pcm_data  <= w_word;
                                    r_pcm_right <= r_chan;
                                    r_pcm_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_PAD: begin
                        // Padding bits are ignored; any slot length is accepted.
                        if (w_ws_edge) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_chan    <= w_ws_s;
                        end
                    end
                    default: begin
                        r_state <= ST_SEEK;
                    end
                endcase
            end
        end
    end

    assign pcm_data_o  = r_pcm_data;
    assign pcm_right_o = r_pcm_right;
    assign pcm_valid_o = r_pcm_valid;
    assign frame_err_o = r_frame_err;
    assign err_count_o = r_err_count;
    assign overrun_o   = r_overrun;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb_i2s_rx_capture: directed I2S frames with hand-computed expected words.
module tb_i2s_rx_capture;

  localparam int DW   = 24;
  localparam int HALF = 32;  // clk cycles per SCK half period (SCK = clk/64)

  logic          clk;
  logic          rst;
  logic          sck;
  logic          ws;
  logic          sd;
  logic [DW-1:0] pcm_data;
  logic          pcm_right;
  logic          pcm_valid;
  logic          pcm_ready;
  logic          frame_err;
  logic [7:0]    err_count;
  logic          overrun;
  logic [1:0]    dbg_state;

  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];
  int          n_checks;
  int          n_errors;
  int          err_pulses;

  i2s_rx_capture #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sck_i       (sck),
    .ws_i        (ws),
    .sd_i        (sd),
    .pcm_data_o  (pcm_data),
    .pcm_right_o (pcm_right),
    .pcm_valid_o (pcm_valid),
    .pcm_ready_i (pcm_ready),
    .frame_err_o (frame_err),
    .err_count_o (err_count),
    .overrun_o   (overrun),
    .dbg_state_o (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: record accepted words and frame error pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (pcm_valid && pcm_ready) got_q.push_back({pcm_right, pcm_data});
      if (frame_err) err_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one SCK period: change WS/SD while SCK is low, receiver samples on the rise
  task automatic sck_bit(input logic w, input logic b);
    sck = 1'b0;
    ws  = w;
    sd  = b;
    wait_clk(HALF);
    sck = 1'b1;
    wait_clk(HALF);
  endtask

  // bits [first, last) of a slot: bit 0 dummy, bits 1..DW data MSB first, rest padding
  task automatic send_slot(input logic w, input logic [DW-1:0] data, input int first, input int last);
    for (int i = first; i < last; i++) begin
      logic b;
      if (i == 0) b = 1'b1;
      else if (i <= DW) b = data[DW-i];
      else b = 1'b1;
      sck_bit(w, b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"}, 32'(pcm_data), 32'h0);
    check({tag, "_right"}, 32'(pcm_right), 32'h0);
    check({tag, "_valid"}, 32'(pcm_valid), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check({tag, "_errcnt"}, 32'(err_count), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    err_pulses = 0;
    rst        = 1'b1;
    sck        = 1'b0;
    ws         = 1'b0;
    sd         = 1'b0;
    pcm_ready  = 1'b1;

    // reset state, and start mid-slot: first 12 SCK of a left slot under reset
    wait_clk(4);
    check_reset_outputs("reset");
    send_slot(1'b0, 24'hA5A5A5, 0, 12);
    rst = 1'b0;
    send_slot(1'b0, 24'hA5A5A5, 12, 32);
    check("midstart_state", 32'(dbg_state), 32'h0);
    check("midstart_nowords", 32'(got_q.size()), 32'h0);

    // nominal frames with ready held high
    send_slot(1'b1, 24'h654321, 0, 32);
    exp_q.push_back({1'b1, 24'h654321});
    send_slot(1'b0, 24'h123456, 0, 32);
    exp_q.push_back({1'b0, 24'h123456});
    send_slot(1'b1, 24'hABCDEF, 0, 32);
    exp_q.push_back({1'b1, 24'hABCDEF});
    check_words("nominal");
    check("nominal_ferr", 32'(err_pulses), 32'h0);
    check("nominal_overrun", 32'(overrun), 32'h0);
    check("nominal_state", 32'(dbg_state), 32'h2);

    // short slot: WS toggles after 10 data bits, then a full slot
    send_slot(1'b0, 24'hFFFFFF, 0, 11);
    send_slot(1'b1, 24'h00FFFF, 0, 32);
    exp_q.push_back({1'b1, 24'h00FFFF});
    check_words("short");
    check("short_ferr_pulses", 32'(err_pulses), 32'h1);
    check("short_errcnt", 32'(err_count), 32'h1);
    check("short_overrun", 32'(overrun), 32'h0);

    // backpressure: two words complete while ready is low
    pcm_ready = 1'b0;
    send_slot(1'b0, 24'h000001, 0, 32);
    send_slot(1'b1, 24'h000002, 0, 32);
    @(negedge clk);
    check("bp_data", 32'(pcm_data), 32'h000001);
    check("bp_right", 32'(pcm_right), 32'h0);
    check("bp_valid", 32'(pcm_valid), 32'h1);
    check("bp_overrun", 32'(overrun), 32'h1);
    check("bp_nowords", 32'(got_q.size()), 32'h0);
    wait_clk(1);
    pcm_ready = 1'b1;
    exp_q.push_back({1'b0, 24'h000001});
    wait_clk(1);
    @(negedge clk);
    check("bp_valid_cleared", 32'(pcm_valid), 32'h0);
    check_words("bp");

    // reset in the middle of a left slot, then a fresh right slot
    send_slot(1'b0, 24'hC3C3C3, 0, 16);
    rst = 1'b1;
    wait_clk(1);
    check_reset_outputs("midreset");
    wait_clk(1);
    rst = 1'b0;
    send_slot(1'b0, 24'hC3C3C3, 16, 32);
    check("midreset_nowords", 32'(got_q.size()), 32'h0);
    check("midreset_state", 32'(dbg_state), 32'h0);
    send_slot(1'b1, 24'h0F0F0F, 0, 32);
    exp_q.push_back({1'b1, 24'h0F0F0F});
    check_words("resume");
    check("resume_errcnt", 32'(err_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
